// File: rtl/layer_controller.sv
// Sequences one bitstream-layer evaluation (clear, optional warmup, counted run, done) and reports per-neuron ones counts.
// Optional feature: define LAYER_CTRL_WARMUP_EN to add WARMUP_CYCLES of uncounted settle time between CLEAR and RUN.
module layer_controller #(
  parameter int NEURON_COUNT  = 2,
  parameter int STREAM_LENGTH = 256,
  parameter int WARMUP_CYCLES = 4,
  localparam int CW = $clog2(STREAM_LENGTH + 1)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NEURON_COUNT-1:0]    layer_output,
  output logic                       layer_n_rst,
  output logic                       busy,
  output logic                       done,
  output logic [NEURON_COUNT*CW-1:0] counts
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
`ifdef LAYER_CTRL_WARMUP_EN
  localparam logic [2:0] WARMUP = 3'd4;
  localparam int TMAX = (WARMUP_CYCLES > STREAM_LENGTH) ? WARMUP_CYCLES : STREAM_LENGTH;
`else
  localparam int TMAX = STREAM_LENGTH;
`endif
  localparam int TW = $clog2(TMAX + 1);

  if (STREAM_LENGTH < 1 || WARMUP_CYCLES < 1) begin : g_bad_cfg
    $error("layer_controller: STREAM_LENGTH and WARMUP_CYCLES must both be at least 1");
  end

  logic [2:0]                 state_q, state_d;
  logic [TW-1:0]              cyc_q, cyc_d;
  logic [NEURON_COUNT*CW-1:0] counts_q, counts_d;
  logic                       layer_n_rst_q, layer_n_rst_d;
  logic                       in_eval;

  assign in_eval = (state_q == CLEAR) || (state_q == RUN)
`ifdef LAYER_CTRL_WARMUP_EN
                   || (state_q == WARMUP)
`endif
                   ;

  always_comb begin
    state_d  = state_q;
    counts_d = counts_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
`ifdef LAYER_CTRL_WARMUP_EN
        state_d = WARMUP;
`else
        state_d = RUN;
`endif
      end
`ifdef LAYER_CTRL_WARMUP_EN
      WARMUP: begin
        if (cyc_q == TW'(WARMUP_CYCLES - 1)) state_d = RUN;
      end
`endif
      RUN: begin
        for (int i = 0; i < NEURON_COUNT; i++) begin
          if (layer_output[i]) counts_d[i*CW +: CW] = counts_q[i*CW +: CW] + CW'(1);
        end
        if (cyc_q == TW'(STREAM_LENGTH - 1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides whatever the active state decided, including the RUN increment.
    if (abort && in_eval) begin
      state_d  = IDLE;
      counts_d = '0;
    end
    if (state_q == IDLE && state_d == CLEAR) counts_d = '0;
  end

  // One shared duration counter, restarted on every state change.
  always_comb begin
    cyc_d = cyc_q;
    if (state_d != state_q) begin
      cyc_d = '0;
    end else if (state_q == RUN
`ifdef LAYER_CTRL_WARMUP_EN
                 || state_q == WARMUP
`endif
                 ) begin
      cyc_d = cyc_q + TW'(1);
    end
  end

  always_comb begin
    layer_n_rst_d = (state_d == RUN) || (state_d == DONE)
`ifdef LAYER_CTRL_WARMUP_EN
                    || (state_d == WARMUP)
`endif
                    ;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      cyc_q         <= '0;
      counts_q      <= '0;
      layer_n_rst_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      counts_q      <= counts_d;
      layer_n_rst_q <= layer_n_rst_d;
    end
  end

  assign busy        = in_eval;
  assign done        = (state_q == DONE);
  assign layer_n_rst = layer_n_rst_q;
  assign counts      = counts_q;

endmodule
